// File: rtl/tdm_sweep_scheduler.sv
// tdm_sweep_scheduler: issues one state-RAM read per cycle across all neurons,
// tracks each read through the fixed-latency core pipeline and emits the
// matching write-back strobe/address. Host runs N sweeps (or free-run) and
// may abort; in-flight entries always drain before done.
module tdm_sweep_scheduler #(
    parameter int neuron_count   = 500,
    parameter int pipeline_depth = 5,
    parameter int step_width     = 16,
    localparam int ptr_width     = $clog2(neuron_count)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [step_width-1:0] num_steps,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [step_width-1:0] step_count,
    output logic                  rd_en,
    output logic [ptr_width-1:0]  rd_addr,
    output logic                  wr_en,
    output logic [ptr_width-1:0]  wr_addr,
    output logic                  sweep_start,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ptr_width-1:0] LAST_ADDR = ptr_width'(neuron_count - 1);

    state_t                                  cur, nxt;
    logic                                    rd_en_nxt;
    logic [ptr_width-1:0]                    rd_addr_nxt;
    logic [step_width-1:0]                   steps_lat;
    logic [step_width-1:0]                   issued_cnt;
    logic                                    abort_flag;
    logic                                    upstream_vld;
    // Last stage of the shift register is the write-back strobe itself.
    logic [pipeline_depth-1:0]               vld_pipe;
    logic [pipeline_depth-1:0][ptr_width-1:0] addr_pipe;

    assign state   = cur;
    assign wr_en   = vld_pipe[pipeline_depth-1];
    assign wr_addr = addr_pipe[pipeline_depth-1];

    // Any entry that will still be in flight after the next edge.
    always_comb begin
        upstream_vld = 1'b0;
        for (int i = 0; i < pipeline_depth - 1; i++)
            upstream_vld = upstream_vld | vld_pipe[i];
    end

    // Next-state and next read strobe/address.
    always_comb begin
        nxt         = cur;
        rd_en_nxt   = 1'b0;
        rd_addr_nxt = rd_addr;
        case (cur)
            IDLE: begin
                if (start && !abort) begin
                    nxt         = RUN;
                    rd_en_nxt   = 1'b1;
                    rd_addr_nxt = '0;
                end
            end
            RUN: begin
                if (abort) begin
                    nxt = DRAIN;
                end else if (steps_lat != '0 && rd_addr == LAST_ADDR &&
                             issued_cnt + step_width'(1) == steps_lat) begin
                    nxt = DRAIN;
                end else begin
                    rd_en_nxt   = 1'b1;
                    rd_addr_nxt = (rd_addr == LAST_ADDR) ? '0 : rd_addr + 1'b1;
                end
            end
            DRAIN: begin
                if (!upstream_vld && !rd_en)
                    nxt = DONE;
            end
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // State register, registered outputs, run counters and pipeline tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur         <= IDLE;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            sweep_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            abort_flag  <= 1'b0;
            step_count  <= '0;
            steps_lat   <= '0;
            issued_cnt  <= '0;
            vld_pipe    <= '0;
            addr_pipe   <= '0;
        end else begin
            cur         <= nxt;
            rd_en       <= rd_en_nxt;
            rd_addr     <= rd_addr_nxt;
            sweep_start <= rd_en_nxt && (rd_addr_nxt == '0);
            busy        <= (nxt == RUN) || (nxt == DRAIN);
            done        <= (nxt == DONE);

            vld_pipe[0]  <= rd_en;
            addr_pipe[0] <= rd_addr;
            for (int i = 1; i < pipeline_depth; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
            end

            if (cur == IDLE && nxt == RUN) begin
                steps_lat  <= num_steps;
                step_count <= '0;
                issued_cnt <= '0;
                aborted    <= 1'b0;
                abort_flag <= 1'b0;
            end else begin
                if (rd_en && rd_addr == LAST_ADDR)
                    issued_cnt <= issued_cnt + 1'b1;
                if (wr_en && wr_addr == LAST_ADDR)
                    step_count <= step_count + 1'b1;
                if (cur == RUN && abort)
                    abort_flag <= 1'b1;
                if (nxt == DONE)
                    aborted <= abort_flag;
            end
        end
    end

endmodule

// File: tb/tb_tdm_sweep_scheduler.sv
// Scoreboard bench for tdm_sweep_scheduler (8 neurons, 3-deep pipeline).
// The driver predicts every read, write and done event of a run from the
// sweep rules and queues them; a negedge monitor pops and compares.
module tb_tdm_sweep_scheduler;
    localparam int N  = 8;
    localparam int D  = 3;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [SW-1:0] num_steps = '0;
    logic          busy, done, aborted, rd_en, wr_en, sweep_start;
    logic [SW-1:0] step_count;
    logic [2:0]    rd_addr, wr_addr;
    logic [1:0]    state;

    tdm_sweep_scheduler #(.neuron_count(N), .pipeline_depth(D), .step_width(SW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .num_steps(num_steps),
        .busy(busy), .done(done), .aborted(aborted), .step_count(step_count),
        .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en), .wr_addr(wr_addr),
        .sweep_start(sweep_start), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int addr; } ev_t;
    typedef struct { int cyc; int ab; int steps; } done_t;

    ev_t   exp_rd[$];
    ev_t   exp_wr[$];
    done_t exp_done[$];
    bit    pending[N];
    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;
    ev_t   mon_e;
    done_t mon_d;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    task automatic flush();
        exp_rd.delete();
        exp_wr.delete();
        exp_done.delete();
        for (int i = 0; i < N; i++) pending[i] = 1'b0;
    endtask

    // Reference: reads at c0+i (addr i mod N) up to the last read index,
    // each written D cycles later, done one cycle after the last write.
    task automatic push_run(input int c0, input int ns, input int abort_j);
        int last;
        done_t d;
        last = (abort_j >= 0) ? abort_j : ns * N - 1;
        for (int i = 0; i <= last; i++) begin
            exp_rd.push_back('{c0 + i, i % N});
            exp_wr.push_back('{c0 + i + D, i % N});
        end
        d.cyc   = c0 + last + D + 1;
        d.ab    = (abort_j >= 0) ? 1 : 0;
        d.steps = ((last + 1) / N) % 65536;
        exp_done.push_back(d);
    endtask

    task automatic run(input int ns, input int abort_j, input bit start_mid);
        int c0, t;
        @(negedge clk);
        num_steps = SW'(ns);
        start = 1'b1;
        c0 = cyc + 1;
        push_run(c0, ns, abort_j);
        @(negedge clk);
        start = 1'b0;
        num_steps = SW'($urandom_range(1, 9));
        chk("start_aborted_clr", int'(aborted), 0);
        chk("start_busy", int'(busy), 1);
        if (start_mid) begin
            @(negedge clk);
            start = 1'b1;
            num_steps = SW'(5);
            @(negedge clk);
            start = 1'b0;
        end
        if (abort_j >= 0) begin
            while (cyc < c0 + abort_j) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
        t = 0;
        while (exp_done.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (exp_done.size() != 0) begin
            fail_now("run_timeout");
            flush();
        end
        repeat (2) @(negedge clk);
        chk("leftover_events", exp_rd.size() + exp_wr.size(), 0);
    endtask

    // Monitor: every strobe the DUT presents must match the next prediction.
    always @(negedge clk) begin
        if (!rst) begin
            if (rd_en) begin
                if (exp_rd.size() == 0) fail_now("unexpected_rd");
                else begin
                    mon_e = exp_rd.pop_front();
                    chk("rd_cycle", cyc, mon_e.cyc);
                    chk("rd_addr", int'(rd_addr), mon_e.addr);
                    chk("sweep_start", int'(sweep_start), int'(mon_e.addr == 0));
                    chk("rd_busy", int'(busy), 1);
                    chk("rd_before_wb", int'(pending[rd_addr]), 0);
                    pending[rd_addr] = 1'b1;
                end
            end else if (sweep_start) begin
                fail_now("sweep_start_without_rd");
            end
            if (wr_en) begin
                if (exp_wr.size() == 0) fail_now("unexpected_wr");
                else begin
                    mon_e = exp_wr.pop_front();
                    chk("wr_cycle", cyc, mon_e.cyc);
                    chk("wr_addr", int'(wr_addr), mon_e.addr);
                    pending[wr_addr] = 1'b0;
                end
            end
            if (done) begin
                if (exp_done.size() == 0) fail_now("unexpected_done");
                else begin
                    mon_d = exp_done.pop_front();
                    chk("done_cycle", cyc, mon_d.cyc);
                    chk("done_aborted", int'(aborted), mon_d.ab);
                    chk("done_step_count", int'(step_count), mon_d.steps);
                    chk("done_state", int'(state), 3);
                    chk("done_busy", int'(busy), 0);
                end
            end
        end
    end

    initial begin
        int c0, ns, aj;
        flush();
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({rd_en, wr_en, busy, done, aborted, sweep_start}), 0);
        chk("reset_state", int'(state), 0);
        chk("reset_step_count", int'(step_count), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run(1, -1, 1'b0);
        run(3, -1, 1'b0);
        run(0, 20, 1'b0);
        run(2, -1, 1'b1);

        // start with abort in IDLE must not launch a run
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        num_steps = SW'(2);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        repeat (5) @(negedge clk);
        chk("start_abort_idle_state", int'(state), 0);
        chk("start_abort_idle_busy", int'(busy), 0);

        // asynchronous reset mid-DRAIN with a write in flight
        @(negedge clk);
        num_steps = SW'(1);
        start = 1'b1;
        c0 = cyc + 1;
        push_run(c0, 1, -1);
        @(negedge clk);
        start = 1'b0;
        do begin
            @(posedge clk);
            #2;
        end while (cyc < c0 + 9);
        chk("pre_rst_wr_en", int'(wr_en), 1);
        rst = 1'b1;
        flush();
        #1;
        chk("rst_async_strobes", int'({wr_en, rd_en, busy, done}), 0);
        chk("rst_async_state", int'(state), 0);
        chk("rst_async_step_count", int'(step_count), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run(1, -1, 1'b0);

        for (int k = 0; k < 8; k++) begin
            ns = $urandom_range(0, 3);
            if (ns == 0) aj = $urandom_range(3, 40);
            else if ($urandom_range(0, 1) == 1) aj = $urandom_range(3, ns * N - 2);
            else aj = -1;
            run(ns, aj, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        failures++;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tdm_sweep_scheduler.md
Name: tdm_sweep_scheduler

Overview:
Sequences the time-multiplexed neuron update datapath. It issues one state-RAM read per cycle across all neurons and tracks each read through the fixed-latency core pipeline. It then emits the matching write-back strobe and address. A host starts a run of N full sweeps (or free-run), can abort, and sees progress and completion flags.

Parameters:
neuron_count, 500, neurons per sweep; must satisfy neuron_count > pipeline_depth.
pipeline_depth, 5, cycles from rd_en (address presented) to the matching write-back.
step_width, 16, width of num_steps and step_count.
(derived) ptr_width = $clog2(neuron_count).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  one-cycle run request; honoured only in IDLE.
abort  in  1  stop issuing reads and drain the pipeline; honoured in RUN.
num_steps  in  step_width  sweeps to run; sampled on accepted start; 0 = free-run until abort.
busy  out  1  high in RUN and DRAIN.
done  out  1  one-cycle pulse when a run finishes (normal or aborted).
aborted  out  1  set with done if the run was aborted; cleared on the next accepted start.
step_count  out  step_width  completed sweeps in the current run; wraps modulo 2^step_width.
rd_en  out  1  state-RAM read strobe.
rd_addr  out  ptr_width  neuron index being read.
wr_en  out  1  state-RAM write-back strobe.
wr_addr  out  ptr_width  neuron index being written.
sweep_start  out  1  high together with rd_en when rd_addr==0 (stimulus latch point).
state  out  2  IDLE=0, RUN=1, DRAIN=2, DONE=3.

Behaviour:
- Reset (asynchronous): state=IDLE. All of the following are forced to 0 immediately, mid-run included: rd_en, wr_en, rd_addr, wr_addr, done, aborted, busy, sweep_start, step_count, and the valid/address shift registers. No write-back strobe may escape after rst rises.
- All outputs are registered.
- IDLE:
  - Sampling start=1 with abort=0: latch num_steps, clear step_count and aborted, go to RUN.
  - The first rd_en (rd_addr=0, sweep_start=1) occurs in the cycle after that edge.
  - start together with abort: stay in IDLE.
- RUN: rd_en=1 every cycle. rd_addr increments by 1 and wraps neuron_count-1 -> 0. A sweep counts as issued when rd_addr=neuron_count-1 is issued.
- RUN exits to DRAIN when either:
  - num_steps != 0 and the issued-sweep count reaches num_steps; the last read is addr neuron_count-1, and rd_en=0 on the next cycle.
  - abort=1 is sampled; rd_en=0 from the next cycle and the partial sweep stops at its current address.
- Pipeline tracking: a pipeline_depth-stage valid+address shift register. Each entry sets wr_en=1, wr_addr=A exactly pipeline_depth cycles after rd_en with rd_addr=A. In-flight entries always complete, including on abort.
- step_count increments on the cycle wr_en=1 with wr_addr=neuron_count-1.
- DRAIN: rd_en=0. Once the shift register holds no valid entry, go to DONE.
- DONE: done=1 for exactly one cycle; aborted=1 if entered via abort; then IDLE.
- Normal run timing: with the first rd in cycle c0, the last wr is in cycle c0 + num_steps*neuron_count - 1 + pipeline_depth, and done is in the following cycle.
- Hazard freedom: neuron_count > pipeline_depth guarantees neuron A is written before it is re-read in the next sweep.
- Ignored inputs:
  - start outside IDLE.
  - abort outside RUN.
- Free-run: step_count wraps silently.

Test Plan:
- Bench uses neuron_count=8, pipeline_depth=3.
- Reset then start with num_steps=1 -> rd_addr 0..7 in cycles c0..c0+7; wr_addr 0..7 in cycles c0+3..c0+10; done in cycle c0+11; step_count=1; aborted=0.
- num_steps=3 -> 24 consecutive reads with rd_addr wrapping 7->0 twice; sweep_start high 3 times; step_count steps 1,2,3; single done pulse; no rd_en/wr_en to the same address within 3 cycles.
- num_steps=0, abort sampled while rd_addr=4 in cycle c0+20 -> rd_en low from c0+21; writes for addrs 2,3,4 still occur in c0+21..c0+23; done and aborted pulse in c0+24; step_count=2.
- start pulsed during RUN, and start together with abort in IDLE -> num_steps is not re-latched, the run is unchanged, and no new run begins.
- rst asserted asynchronously mid-DRAIN with an in-flight write -> wr_en, rd_en and busy drop without waiting for a clock edge; state=0; step_count=0; a subsequent start behaves as in scenario 1.
